traffic_phase_controller: RTL and testbench
===========================================

// Module: traffic_phase_controller
// PURPOSE
//  Parametrised N-lane intersection controller; successor to the fixed 8-lane top-level.
//  Replaces the mux-selected per-mode light outputs with one phase state machine.
//  Phases: green/amber/all-red, occupancy-weighted green time, pedestrian walk,
//  emergency pre-emption, and night flashing amber.
//  Driven by the system clock, with a 1 Hz tick enable. Sits directly under the board top level.
// PARAMETERS
//  NUM_LANES    8   number of lanes (2..16); LANE_W = $clog2(NUM_LANES)
//  CNT_W        8   width of each lane occupancy count
//  TMR_W        7   width of the phase timer (durations in ticks)
//  MIN_GREEN    5   base green ticks
//  SEC_PER_CAR  2   extra green ticks per queued car
//  MAX_GREEN    60  green-time cap (must be < 2**TMR_W)
//  AMBER_TIME   3   amber ticks
//  ALLRED_TIME  2   all-red clearance ticks
//  WALK_TIME    10  pedestrian walk ticks
// PORTS
//  clk         in   1                  system clock
//  rst         in   1                  synchronous reset, active-low
//  tick        in   1                  1-tick-per-second enable; all timing counts ticks
//  night_mode  in   1                  1 = night operation requested
//  ped_req     in   1                  pedestrian button (pulse or level)
//  emg_req     in   1                  emergency vehicle present (level)
//  emg_lane    in   LANE_W             lane requested by the emergency vehicle
//  lane_count  in   NUM_LANES*CNT_W    queued cars; lane i = [i*CNT_W +: CNT_W]
//  green       out  NUM_LANES          green lamps
//  amber       out  NUM_LANES          amber lamps
//  red         out  NUM_LANES          red lamps
//  walk        out  1                  pedestrian walk lamp
//  mode        out  2                  0 day, 1 night, 2 pedestrian, 3 emergency
//  cur_lane    out  LANE_W             lane currently owning green/amber
// BEHAVIOUR
//  States: ALLRED, GREEN, AMBER, WALK, EMG, NIGHT_ON, NIGHT_OFF. All outputs are registered.
//  Reset (rst==0 at clk edge) forces the following:
//  - state=ALLRED, timer=ALLRED_TIME-1, cur_lane=0, ped_pend=0, emg_hold=0.
//  - Lamps: green=0, amber=0, red=all-1s, walk=0, mode=0.
//  - Reset mid-phase aborts the phase; no amber is shown.
//  Timer: loaded with D-1 on phase entry and decremented on tick.
//  - Phase ends on (tick && timer==0), so each phase lasts exactly D ticks.
//  - Without tick, nothing changes except the request latches.
//  Green time: G = min(MIN_GREEN + lane_count[lane]*SEC_PER_CAR, MAX_GREEN).
//  - Computed at full width before the clamp; no wrap allowed.
//  ped_pend: set whenever ped_req==1; cleared on WALK entry. Requests arriving during WALK are lost.
//  ALLRED exit priority (highest first):
//  - emg_req: enter EMG, latch emg_hold=emg_lane.
//  - ped_pend: enter WALK.
//  - night_mode: enter NIGHT_ON.
//  - Otherwise enter GREEN on the next lane after cur_lane (mod NUM_LANES) with nonzero count.
//    If all counts are zero, take cur_lane+1 with G=MIN_GREEN.
//  GREEN -> AMBER on timer end.
//  GREEN with emg_req=1 and emg_lane!=cur_lane: go to AMBER immediately, timer=AMBER_TIME-1.
//  GREEN with emg_req=1 and emg_lane==cur_lane: go to EMG on the same cycle, green held.
//  AMBER -> ALLRED on timer end.
//  WALK: all red, walk=1. Exits to ALLRED on timer end, then resumes the round-robin.
//  WALK with emg_req=1: go to ALLRED immediately (walk=0); ped_pend is not re-set.
//  EMG: green only on emg_hold, all others red.
//  - emg_lane changes are ignored while in EMG.
//  - On emg_req==0, go to AMBER on emg_hold; cur_lane=emg_hold so the next green is emg_hold+1.
//  NIGHT_ON/NIGHT_OFF: toggle each tick. amber=all-1s in ON, 0 in OFF. red=0, green=0.
//  - Exit to ALLRED when night_mode==0, or emg_req, or ped_pend.
//  Lamp invariant: per lane, exactly one of green/amber/red is set outside NIGHT.
//  - No lane is ever green while walk==1.
//  mode: 3 in EMG, 2 in WALK, 1 in NIGHT_*, else 0.
// TESTING
//  1. Reset, counts all 0, tick every cycle -> lane 0 ALLRED 2 ticks; lane 1 green 5, amber 3, allred 2; then lane 2.
//  2. lane_count[3]=40, others 0 -> lane 3 green exactly 60 ticks (clamped); lanes 1,2 skipped.
//  3. ped_req pulse mid-green on lane 1 -> amber 3, allred 2, walk=1 for 10 ticks, allred 2, green on lane 2.
//  4. emg_req=1, emg_lane=5 during lane 2 green -> amber 3, allred 2, EMG green[5] until release.
//     Release -> amber on 5, then green on lane 6.
//  5. night_mode=1 -> after allred, amber toggles 1/0 per tick; ped_req -> allred, walk, allred, back to NIGHT.
//  6. rst=0 for one cycle mid-amber -> next cycle red=all-1s, walk=0, mode=0, cur_lane=0; tick gaps hold state.

Source files
------------

// File: rtl/traffic_phase_controller.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_controller
// Purpose  : N-lane intersection phase FSM: occupancy-weighted green, amber,
//            all-red clearance, pedestrian walk, emergency pre-emption, night flash.
// Revision : 1.0  initial release
// ============================================================================
module traffic_phase_controller #(
  parameter int  NUM_LANES   = 8,
  parameter int  CNT_W       = 8,
  parameter int  TMR_W       = 7,
  parameter int  MIN_GREEN   = 5,
  parameter int  SEC_PER_CAR = 2,
  parameter int  MAX_GREEN   = 60,
  parameter int  AMBER_TIME  = 3,
  parameter int  ALLRED_TIME = 2,
  parameter int  WALK_TIME   = 10,
  localparam int LANE_W      = $clog2(NUM_LANES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic                       night_mode,
  input  logic                       ped_req,
  input  logic                       emg_req,
  input  logic [LANE_W-1:0]          emg_lane,
  input  logic [NUM_LANES*CNT_W-1:0] lane_count,
  output logic [NUM_LANES-1:0]       green,
  output logic [NUM_LANES-1:0]       amber,
  output logic [NUM_LANES-1:0]       red,
  output logic                       walk,
  output logic [1:0]                 mode,
  output logic [LANE_W-1:0]          cur_lane
);

  typedef enum logic [2:0] {
    S_ALLRED    = 3'd0,
    S_GREEN     = 3'd1,
    S_AMBER     = 3'd2,
    S_WALK      = 3'd3,
    S_EMG       = 3'd4,
    S_NIGHT_ON  = 3'd5,
    S_NIGHT_OFF = 3'd6
  } state_t;

  localparam logic [TMR_W-1:0]     c_ALLRED_LD = TMR_W'(ALLRED_TIME - 1);
  localparam logic [TMR_W-1:0]     c_AMBER_LD  = TMR_W'(AMBER_TIME - 1);
  localparam logic [TMR_W-1:0]     c_WALK_LD   = TMR_W'(WALK_TIME - 1);
  localparam logic [TMR_W-1:0]     c_MAXG_LD   = TMR_W'(MAX_GREEN - 1);
  localparam logic [TMR_W-1:0]     c_TMR_ONE   = TMR_W'(1);
  localparam logic [LANE_W-1:0]    c_LAST_LANE = LANE_W'(NUM_LANES - 1);
  localparam logic [LANE_W-1:0]    c_LANE_ONE  = LANE_W'(1);
  localparam logic [NUM_LANES-1:0] c_OH_ONE    = NUM_LANES'(1);
  localparam logic [1:0]           c_MODE_DAY  = 2'd0;
  localparam logic [1:0]           c_MODE_NGT  = 2'd1;
  localparam logic [1:0]           c_MODE_PED  = 2'd2;
  localparam logic [1:0]           c_MODE_EMG  = 2'd3;

  state_t                r_state, w_state_nx;
  logic [TMR_W-1:0]      r_timer, w_timer_nx, w_green_ld;
  logic [LANE_W-1:0]     r_cur_lane, w_lane_nx, r_emg_hold, w_hold_nx;
  logic                  r_ped_pend, w_ped_nx;
  logic [NUM_LANES-1:0]  r_green, r_amber, r_red;
  logic [NUM_LANES-1:0]  w_green_nx, w_amber_nx, w_red_nx, w_oh_lane, w_oh_hold;
  logic                  r_walk, w_walk_nx;
  logic [1:0]            r_mode, w_mode_nx;
  logic [CNT_W-1:0]      w_cnt [NUM_LANES];
  logic [NUM_LANES-1:0]  w_busy;
  logic [LANE_W-1:0]     w_lane_inc, w_rr_lane, w_hi_lane, w_lo_lane;
  logic                  w_hi_found, w_lo_found, w_tmr_end;
  logic [31:0]           w_g_full;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign w_cnt[gi]  = lane_count[gi*CNT_W +: CNT_W];
    assign w_busy[gi] = |lane_count[gi*CNT_W +: CNT_W];
  end

  assign w_lane_inc = (r_cur_lane == c_LAST_LANE) ? '0 : r_cur_lane + c_LANE_ONE;
  assign w_tmr_end  = (r_timer == '0);

  // Round robin: the lowest busy lane above cur_lane wins, else the lowest busy lane at or below it.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_lane  = '0;
    w_lo_lane  = '0;
    for (int j = NUM_LANES - 1; j >= 0; j--) begin
      if (w_busy[j]) begin
        if (LANE_W'(j) > r_cur_lane) begin
          w_hi_found = 1'b1;
          w_hi_lane  = LANE_W'(j);
        end else begin
          w_lo_found = 1'b1;
          w_lo_lane  = LANE_W'(j);
        end
      end
    end
    if (w_hi_found)      w_rr_lane = w_hi_lane;
    else if (w_lo_found) w_rr_lane = w_lo_lane;
    else                 w_rr_lane = w_lane_inc;
  end

  assign w_g_full   = 32'(MIN_GREEN) + 32'(w_cnt[w_rr_lane]) * 32'(SEC_PER_CAR);
  assign w_green_ld = (w_g_full > 32'(MAX_GREEN)) ? c_MAXG_LD : TMR_W'(w_g_full - 32'd1);

  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer;
    w_lane_nx  = r_cur_lane;
    w_hold_nx  = r_emg_hold;
    if (tick) begin
      case (r_state)
        S_ALLRED: begin
          if (!w_tmr_end) begin
            w_timer_nx = r_timer - c_TMR_ONE;
          end else if (emg_req) begin
            w_state_nx = S_EMG;
            w_hold_nx  = emg_lane;
          end else if (r_ped_pend) begin
            w_state_nx = S_WALK;
            w_timer_nx = c_WALK_LD;
          end else if (night_mode) begin
            w_state_nx = S_NIGHT_ON;
          end else begin
            w_state_nx = S_GREEN;
            w_lane_nx  = w_rr_lane;
            w_timer_nx = w_green_ld;
          end
        end
        S_GREEN: begin
          if (emg_req && (emg_lane == r_cur_lane)) begin
            w_state_nx = S_EMG;
            w_hold_nx  = r_cur_lane;
          end else if (emg_req || w_tmr_end) begin
            w_state_nx = S_AMBER;
            w_timer_nx = c_AMBER_LD;
          end else begin
            w_timer_nx = r_timer - c_TMR_ONE;
          end
        end
        S_AMBER: begin
          if (w_tmr_end) begin
            w_state_nx = S_ALLRED;
            w_timer_nx = c_ALLRED_LD;
          end else begin
            w_timer_nx = r_timer - c_TMR_ONE;
          end
        end
        S_WALK: begin
          if (emg_req || w_tmr_end) begin
            w_state_nx = S_ALLRED;
            w_timer_nx = c_ALLRED_LD;
          end else begin
            w_timer_nx = r_timer - c_TMR_ONE;
          end
        end
        S_EMG: begin
          if (!emg_req) begin
            w_state_nx = S_AMBER;
            w_timer_nx = c_AMBER_LD;
            w_lane_nx  = r_emg_hold;
          end
        end
        S_NIGHT_ON, S_NIGHT_OFF: begin
          if (!night_mode || emg_req || r_ped_pend) begin
            w_state_nx = S_ALLRED;
            w_timer_nx = c_ALLRED_LD;
          end else begin
            w_state_nx = (r_state == S_NIGHT_ON) ? S_NIGHT_OFF : S_NIGHT_ON;
          end
        end
        default: begin
          w_state_nx = S_ALLRED;
          w_timer_nx = c_ALLRED_LD;
        end
      endcase
    end
    if ((w_state_nx == S_WALK) && (r_state != S_WALK)) w_ped_nx = 1'b0;
    else w_ped_nx = r_ped_pend | (ped_req && (r_state != S_WALK));
  end

  // Lamps are decoded from the next state so they change on the same edge as the FSM.
  assign w_oh_lane = c_OH_ONE << w_lane_nx;
  assign w_oh_hold = c_OH_ONE << w_hold_nx;

  always_comb begin
    w_green_nx = '0;
    w_amber_nx = '0;
    w_red_nx   = '1;
    w_walk_nx  = 1'b0;
    w_mode_nx  = c_MODE_DAY;
    case (w_state_nx)
      S_GREEN: begin
        w_green_nx = w_oh_lane;
        w_red_nx   = ~w_oh_lane;
      end
      S_AMBER: begin
        w_amber_nx = w_oh_lane;
        w_red_nx   = ~w_oh_lane;
      end
      S_WALK: begin
        w_walk_nx  = 1'b1;
        w_mode_nx  = c_MODE_PED;
      end
      S_EMG: begin
        w_green_nx = w_oh_hold;
        w_red_nx   = ~w_oh_hold;
        w_mode_nx  = c_MODE_EMG;
      end
      S_NIGHT_ON: begin
        w_amber_nx = '1;
        w_red_nx   = '0;
        w_mode_nx  = c_MODE_NGT;
      end
      S_NIGHT_OFF: begin
        w_red_nx   = '0;
        w_mode_nx  = c_MODE_NGT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_ALLRED;
      r_timer    <= c_ALLRED_LD;
      r_cur_lane <= '0;
      r_ped_pend <= 1'b0;
      r_emg_hold <= '0;
      r_green    <= '0;
      r_amber    <= '0;
      r_red      <= '1;
      r_walk     <= 1'b0;
      r_mode     <= c_MODE_DAY;
    end else begin
      r_state    <= w_state_nx;
      r_timer    <= w_timer_nx;
      r_cur_lane <= w_lane_nx;
      r_ped_pend <= w_ped_nx;
      r_emg_hold <= w_hold_nx;
      r_green    <= w_green_nx;
      r_amber    <= w_amber_nx;
      r_red      <= w_red_nx;
      r_walk     <= w_walk_nx;
      r_mode     <= w_mode_nx;
    end
  end

  assign green    = r_green;
  assign amber    = r_amber;
  assign red      = r_red;
  assign walk     = r_walk;
  assign mode     = r_mode;
  assign cur_lane = r_cur_lane;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_controller
// Purpose  : Phase-sequence vectors for traffic_phase_controller, scoreboarded per clock.
// Revision : 1.0  initial release
// ============================================================================
module tb_traffic_phase_controller;

  typedef enum logic [2:0] {K_AR, K_GR, K_AM, K_WK, K_EM, K_NON, K_NOFF} kind_t;

  // One record: inputs held for cyc clocks, each of which must show the given phase.
  typedef struct {
    logic        rn;
    logic        tk;
    logic        nt;
    logic        pd;
    logic        em;
    logic [2:0]  el;
    logic [63:0] cnt;
    int          cyc;
    kind_t       k;
    logic [2:0]  ll;
    logic [2:0]  cl;
  } vec_t;

  localparam logic [63:0] c_C0 = 64'd0;
  localparam logic [63:0] c_C3 = 64'd40 << 24;
  localparam logic [63:0] c_C7 = (64'd27 << 8) | (64'd255 << 16);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        night_mode = 1'b0;
  logic        ped_req = 1'b0;
  logic        emg_req = 1'b0;
  logic [2:0]  emg_lane = '0;
  logic [63:0] lane_count = '0;
  logic [7:0]  green, amber, red;
  logic        walk;
  logic [1:0]  mode;
  logic [2:0]  cur_lane;

  vec_t        tbl[$];
  logic [29:0] exp_q[$];
  int          n_pass = 0;
  int          n_chk  = 0;
  int          hid    = 1000;

  traffic_phase_controller dut (
    .clk(clk), .rst(rst), .tick(tick), .night_mode(night_mode), .ped_req(ped_req),
    .emg_req(emg_req), .emg_lane(emg_lane), .lane_count(lane_count),
    .green(green), .amber(amber), .red(red), .walk(walk), .mode(mode), .cur_lane(cur_lane)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] exp_out(input kind_t k, input logic [2:0] ll, input logic [2:0] cl);
    logic [7:0] oh, g, a, r;
    logic       w;
    logic [1:0] m;
    oh = 8'd1 << ll;
    g = '0; a = '0; r = '1; w = 1'b0; m = 2'd0;
    case (k)
      K_GR:   begin g = oh; r = ~oh; end
      K_AM:   begin a = oh; r = ~oh; end
      K_WK:   begin w = 1'b1; m = 2'd2; end
      K_EM:   begin g = oh; r = ~oh; m = 2'd3; end
      K_NON:  begin a = '1; r = '0; m = 2'd1; end
      K_NOFF: begin r = '0; m = 2'd1; end
      default: ;
    endcase
    return {g, a, r, w, m, cl};
  endfunction

  task automatic check(input int id, input int c);
    logic [29:0] got, want;
    got = {green, amber, red, walk, mode, cur_lane};
    n_chk++;
    if (exp_q.size() == 0) begin
      $display("FAIL vec%0d/%0d: scoreboard empty, got %h", id, c, got);
    end else begin
      want = exp_q.pop_front();
      if (got === want) n_pass++;
      else $display("FAIL vec%0d/%0d: got g=%b a=%b r=%b w=%b m=%0d l=%0d, want g=%b a=%b r=%b w=%b m=%0d l=%0d",
                    id, c, got[29:22], got[21:14], got[13:6], got[5], got[4:3], got[2:0],
                    want[29:22], want[21:14], want[13:6], want[5], want[4:3], want[2:0]);
    end
  endtask

  task automatic run(input vec_t v, input int id);
    for (int c = 0; c < v.cyc; c++) begin
      rst = v.rn; tick = v.tk; night_mode = v.nt; ped_req = v.pd;
      emg_req = v.em; emg_lane = v.el; lane_count = v.cnt;
      exp_q.push_back(exp_out(v.k, v.ll, v.cl));
      @(posedge clk);
      #1;
      check(id, c);
    end
  endtask

  task automatic mk(output vec_t v, input logic rn, tk, nt, pd, em, input logic [2:0] el,
                    input logic [63:0] cnt, input int cyc, input kind_t k, input logic [2:0] ll, cl);
    v.rn = rn; v.tk = tk; v.nt = nt; v.pd = pd; v.em = em; v.el = el;
    v.cnt = cnt; v.cyc = cyc; v.k = k; v.ll = ll; v.cl = cl;
  endtask

  task automatic add(input logic rn, tk, nt, pd, em, input logic [2:0] el,
                     input logic [63:0] cnt, input int cyc, input kind_t k, input logic [2:0] ll, cl);
    vec_t v;
    mk(v, rn, tk, nt, pd, em, el, cnt, cyc, k, ll, cl);
    tbl.push_back(v);
  endtask

  task automatic step(input logic rn, tk, nt, pd, em, input logic [2:0] el,
                      input logic [63:0] cnt, input int cyc, input kind_t k, input logic [2:0] ll, cl);
    vec_t v;
    mk(v, rn, tk, nt, pd, em, el, cnt, cyc, k, ll, cl);
    run(v, hid);
    hid++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    // Idle round robin from reset
    add(0,1,0,0,0,0,c_C0, 2,K_AR,0,0);
    add(1,1,0,0,0,0,c_C0, 1,K_AR,0,0);
    add(1,1,0,0,0,0,c_C0, 5,K_GR,1,1);
    add(1,1,0,0,0,0,c_C0, 3,K_AM,1,1);
    add(1,1,0,0,0,0,c_C0, 2,K_AR,1,1);
    add(1,1,0,0,0,0,c_C0, 5,K_GR,2,2);
    add(1,1,0,0,0,0,c_C0, 3,K_AM,2,2);
    add(1,1,0,0,0,0,c_C0, 2,K_AR,2,2);
    // Lane 3 loaded: clamp to MAX_GREEN, empty lanes skipped, wraps onto itself
    add(0,1,0,0,0,0,c_C3, 1,K_AR,0,0);
    add(1,1,0,0,0,0,c_C3, 1,K_AR,0,0);
    add(1,1,0,0,0,0,c_C3,60,K_GR,3,3);
    add(1,1,0,0,0,0,c_C3, 3,K_AM,3,3);
    add(1,1,0,0,0,0,c_C3, 2,K_AR,3,3);
    add(1,1,0,0,0,0,c_C3, 2,K_GR,3,3);
    // Pedestrian pulse mid-green
    add(0,1,0,0,0,0,c_C0, 1,K_AR,0,0);
    add(1,1,0,0,0,0,c_C0, 1,K_AR,0,0);
    add(1,1,0,0,0,0,c_C0, 2,K_GR,1,1);
    add(1,1,0,1,0,0,c_C0, 1,K_GR,1,1);
    add(1,1,0,0,0,0,c_C0, 2,K_GR,1,1);
    add(1,1,0,0,0,0,c_C0, 3,K_AM,1,1);
    add(1,1,0,0,0,0,c_C0, 2,K_AR,1,1);
    add(1,1,0,0,0,0,c_C0,10,K_WK,1,1);
    add(1,1,0,0,0,0,c_C0, 2,K_AR,1,1);
    add(1,1,0,0,0,0,c_C0, 2,K_GR,2,2);
    // Emergency on another lane, emg_lane change ignored, release
    add(1,1,0,0,1,5,c_C0, 3,K_AM,2,2);
    add(1,1,0,0,1,5,c_C0, 2,K_AR,2,2);
    add(1,1,0,0,1,5,c_C0, 3,K_EM,5,2);
    add(1,1,0,0,1,1,c_C0, 3,K_EM,5,2);
    add(1,1,0,0,0,0,c_C0, 3,K_AM,5,5);
    add(1,1,0,0,0,0,c_C0, 2,K_AR,5,5);
    add(1,1,0,0,0,0,c_C0, 2,K_GR,6,6);
    // Emergency on the current green lane: straight to EMG
    add(1,1,0,0,1,6,c_C0, 2,K_EM,6,6);
    add(1,1,0,0,0,0,c_C0, 3,K_AM,6,6);
    add(1,1,0,0,0,0,c_C0, 2,K_AR,6,6);
    add(1,1,0,0,0,0,c_C0, 1,K_GR,7,7);
    // Emergency aborts a walk
    add(1,1,0,1,0,0,c_C0, 1,K_GR,7,7);
    add(1,1,0,0,0,0,c_C0, 3,K_GR,7,7);
    add(1,1,0,0,0,0,c_C0, 3,K_AM,7,7);
    add(1,1,0,0,0,0,c_C0, 2,K_AR,7,7);
    add(1,1,0,0,0,0,c_C0, 3,K_WK,7,7);
    add(1,1,0,0,1,0,c_C0, 2,K_AR,7,7);
    add(1,1,0,0,1,0,c_C0, 2,K_EM,0,7);
    add(1,1,0,0,0,0,c_C0, 3,K_AM,0,0);
    add(1,1,0,0,0,0,c_C0, 2,K_AR,0,0);
    add(1,1,0,0,0,0,c_C0, 1,K_GR,1,1);
    // Night flashing, pedestrian service from night, night exit
    add(1,1,1,0,0,0,c_C0, 4,K_GR,1,1);
    add(1,1,1,0,0,0,c_C0, 3,K_AM,1,1);
    add(1,1,1,0,0,0,c_C0, 2,K_AR,1,1);
    add(1,1,1,0,0,0,c_C0, 1,K_NON,1,1);
    add(1,1,1,0,0,0,c_C0, 1,K_NOFF,1,1);
    add(1,1,1,0,0,0,c_C0, 1,K_NON,1,1);
    add(1,1,1,0,0,0,c_C0, 1,K_NOFF,1,1);
    add(1,1,1,1,0,0,c_C0, 1,K_NON,1,1);
    add(1,1,1,0,0,0,c_C0, 2,K_AR,1,1);
    add(1,1,1,0,0,0,c_C0,10,K_WK,1,1);
    add(1,1,1,0,0,0,c_C0, 2,K_AR,1,1);
    add(1,1,1,0,0,0,c_C0, 1,K_NON,1,1);
    add(1,1,1,0,0,0,c_C0, 1,K_NOFF,1,1);
    add(1,1,0,0,0,0,c_C0, 2,K_AR,1,1);
    add(1,1,0,0,0,0,c_C0, 1,K_GR,2,2);
    // Green just below the cap, then a full-scale count that must clamp, not wrap
    add(0,1,0,0,0,0,c_C7, 1,K_AR,0,0);
    add(1,1,0,0,0,0,c_C7, 1,K_AR,0,0);
    add(1,1,0,0,0,0,c_C7,59,K_GR,1,1);
    add(1,1,0,0,0,0,c_C7, 3,K_AM,1,1);
    add(1,1,0,0,0,0,c_C7, 2,K_AR,1,1);
    add(1,1,0,0,0,0,c_C7,60,K_GR,2,2);
    add(1,1,0,0,0,0,c_C7, 1,K_AM,2,2);

    for (int i = 0; i < tbl.size(); i++) run(tbl[i], i);

    // Reset mid-amber, then tick gaps freeze the phase while ped_req still latches
    step(0,1,0,0,0,0,c_C0, 1,K_AR,0,0);
    step(1,1,0,0,0,0,c_C0, 1,K_AR,0,0);
    step(1,1,0,0,0,0,c_C0, 5,K_GR,1,1);
    step(1,1,0,0,0,0,c_C0, 1,K_AM,1,1);
    step(0,1,0,0,0,0,c_C0, 1,K_AR,0,0);
    step(1,0,0,0,0,0,c_C0, 3,K_AR,0,0);
    step(1,1,0,0,0,0,c_C0, 1,K_AR,0,0);
    step(1,1,0,0,0,0,c_C0, 1,K_GR,1,1);
    step(1,0,0,0,0,0,c_C0, 1,K_GR,1,1);
    step(1,0,0,1,0,0,c_C0, 1,K_GR,1,1);
    step(1,0,0,0,0,0,c_C0, 2,K_GR,1,1);
    step(1,1,0,0,0,0,c_C0, 4,K_GR,1,1);
    step(1,1,0,0,0,0,c_C0, 3,K_AM,1,1);
    step(1,1,0,0,0,0,c_C0, 2,K_AR,1,1);
    step(1,1,0,0,0,0,c_C0, 2,K_WK,1,1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
